// File: rtl/fir.sv
// Direct-form FIR filter: ORDER-tap delay line, registered exact products,
// then a registered sum that is scaled by 2^-(COEF_WIDTH-1) and saturated.
module fir #(
  parameter int ORDER      = 61,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter logic [ORDER*COEF_WIDTH-1:0] COEF = {ORDER{COEF_WIDTH'(2)}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         vld_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         vld_o
);

  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(ORDER);

  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [COEF_WIDTH-1:0] coef  [ORDER];
  logic signed [DATA_WIDTH-1:0] taps  [ORDER];
  logic signed [PROD_W-1:0]     prod  [ORDER];
  logic                         vld_s1;
  logic                         vld_s2;

  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      scaled;
  logic signed [DATA_WIDTH-1:0] sat;

  for (genvar g = 0; g < ORDER; g++) begin : g_coef
    assign coef[g] = COEF[g*COEF_WIDTH +: COEF_WIDTH];
  end

  // S1: delay line, newest sample at index 0; idle cycles hold the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history must restart from zero after reset, so every
      // delay-line and product register is cleared, not just the valid bits.
      for (int k = 0; k < ORDER; k++) taps[k] <= '0;
      vld_s1 <= 1'b0;
    end else begin
      if (vld_i) begin
        for (int k = ORDER - 1; k > 0; k--) taps[k] <= taps[k-1];
        taps[0] <= data_i;
      end
      vld_s1 <= vld_i;
    end
  end

  // S2: exact signed products, only refreshed when a new sample arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) prod[k] <= '0;
      vld_s2 <= 1'b0;
    end else begin
      if (vld_s1) begin
        for (int k = 0; k < ORDER; k++)
          prod[k] <= PROD_W'(taps[k]) * PROD_W'(coef[k]);
      end
      vld_s2 <= vld_s1;
    end
  end

  // Adder tree, floor-scaling and clamp feeding the output register.
  always_comb begin
    // NOTE: blocking assignments with a default first: acc is a running
    // combinational sum, and the default keeps every path assigned (no latch).
    acc = '0;
    for (int k = 0; k < ORDER; k++) acc = acc + ACC_W'(prod[k]);
    scaled = acc >>> (COEF_WIDTH - 1);
    if (scaled > ACC_W'(OUT_MAX))      sat = OUT_MAX;
    else if (scaled < ACC_W'(OUT_MIN)) sat = OUT_MIN;
    else                               sat = scaled[DATA_WIDTH-1:0];
  end

  // S3: data_o only moves on a strobe so it holds between outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
      vld_o  <= 1'b0;
    end else begin
      if (vld_s2) data_o <= sat;
      vld_o <= vld_s2;
    end
  end

endmodule

// File: tb/tb_fir.sv
// Self-checking bench for fir: four configurations share one stimulus stream and
// are compared every cycle with an arithmetic model of the filter.
module tb_fir;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] dout [4];
  logic       vout [4];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: accepted samples (newest first), taps per instance,
  // expected output pipeline and the value data_o should be holding.
  int         hist     [61];
  int         coef_tab [4][61];
  logic       exp_v    [3];
  logic [7:0] exp_d    [4][3];
  logic [7:0] exp_hold [4];

  always #5 clk = ~clk;

  fir #(.ORDER(4), .COEF({8'h08, 8'h10, 8'h20, 8'h40})) u_imp (
    .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
    .data_o(dout[0]), .vld_o(vout[0]));

  fir #(.ORDER(4), .COEF({4{8'h7F}})) u_sat (
    .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
    .data_o(dout[1]), .vld_o(vout[1]));

  fir #(.ORDER(4), .COEF({24'h000000, 8'h40})) u_half (
    .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
    .data_o(dout[2]), .vld_o(vout[2]));

  fir u_dflt (
    .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
    .data_o(dout[3]), .vld_o(vout[3]));

  // Filter output for instance i: exact dot product, floor division, clamp.
  function automatic logic [7:0] model(input int i);
    longint acc = 0;
    longint q;
    for (int k = 0; k < 61; k++) acc += longint'(hist[k]) * longint'(coef_tab[i][k]);
    q = acc / 128;
    if ((acc % 128) != 0 && acc < 0) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  // Drive one cycle of inputs and advance the model past that edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    rst    = r;
    vld_i  = v;
    data_i = d;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 61; k++) hist[k] = 0;
      for (int s = 0; s < 3; s++) exp_v[s] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        exp_hold[i] = 8'h00;
        for (int s = 0; s < 3; s++) exp_d[i][s] = 8'h00;
      end
    end else begin
      if (v) begin
        for (int k = 60; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(d));
      end
      exp_v[2] = exp_v[1];
      exp_v[1] = exp_v[0];
      exp_v[0] = v;
      for (int i = 0; i < 4; i++) begin
        exp_d[i][2] = exp_d[i][1];
        exp_d[i][1] = exp_d[i][0];
        exp_d[i][0] = model(i);
        if (exp_v[2]) exp_hold[i] = exp_d[i][2];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (vout[i] !== 1'b0 || dout[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset inst%0d: got vld=%b data=%h, want vld=0 data=00", i, vout[i], dout[i]);
      end
    end
  endtask

  task automatic test_impulse();
    logic [7:0] want [5] = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h00};
    logic [7:0] got [$];
    int first = -1;
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, (c == 0) ? 8'h40 : 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (vout[i] !== exp_v[2] || dout[i] !== exp_hold[i]) begin
          n_fail++;
          $display("FAIL impulse inst%0d c%0d: got vld=%b data=%h, want vld=%b data=%h",
                   i, c, vout[i], dout[i], exp_v[2], exp_hold[i]);
        end
      end
      if (vout[0] === 1'b1) begin
        if (first < 0) first = c;
        got.push_back(dout[0]);
      end
    end
    n_tests++;
    if (first != 2) begin
      n_fail++;
      $display("FAIL impulse_latency: got first strobe at cycle %0d, want 2", first);
    end
    for (int j = 0; j < 5; j++) begin
      n_tests++;
      if (got.size() <= j || got[j] !== want[j]) begin
        n_fail++;
        $display("FAIL impulse_seq[%0d]: got %h, want %h", j,
                 (got.size() > j) ? got[j] : 8'hxx, want[j]);
      end
    end
  endtask

  task automatic test_pos_sat();
    logic [7:0] want [4] = '{8'h7E, 8'h7F, 8'h7F, 8'h7F};
    logic [7:0] got [$];
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 8'h7F, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (vout[i] !== exp_v[2] || dout[i] !== exp_hold[i]) begin
          n_fail++;
          $display("FAIL pos_sat inst%0d c%0d: got vld=%b data=%h, want vld=%b data=%h",
                   i, c, vout[i], dout[i], exp_v[2], exp_hold[i]);
        end
      end
      if (vout[1] === 1'b1) got.push_back(dout[1]);
    end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (got.size() <= j || got[j] !== want[j]) begin
        n_fail++;
        $display("FAIL pos_sat_seq[%0d]: got %h, want %h", j,
                 (got.size() > j) ? got[j] : 8'hxx, want[j]);
      end
    end
  endtask

  task automatic test_neg_sat();
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 8'h80, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (vout[i] !== exp_v[2] || dout[i] !== exp_hold[i]) begin
          n_fail++;
          $display("FAIL neg_sat inst%0d c%0d: got vld=%b data=%h, want vld=%b data=%h",
                   i, c, vout[i], dout[i], exp_v[2], exp_hold[i]);
        end
      end
    end
    n_tests++;
    if (dout[1] !== 8'h80) begin
      n_fail++;
      $display("FAIL neg_sat_steady: got %h, want 80", dout[1]);
    end
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b1, 8'hFF, 1'b0);
    n_tests++;
    if (vout[2] !== 1'b1 || dout[2] !== 8'hFF) begin
      n_fail++;
      $display("FAIL truncate_floor: got vld=%b data=%h, want vld=1 data=ff", vout[2], dout[2]);
    end
  endtask

  task automatic test_valid_gating();
    logic [7:0] got [$];
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      step(1'b1, 8'h40, 1'b0);
      else if (c == 6) step(1'b1, 8'h00, 1'b0);
      else             step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (vout[i] !== exp_v[2] || dout[i] !== exp_hold[i]) begin
          n_fail++;
          $display("FAIL gating inst%0d c%0d: got vld=%b data=%h, want vld=%b data=%h",
                   i, c, vout[i], dout[i], exp_v[2], exp_hold[i]);
        end
      end
      if (vout[0] === 1'b1) got.push_back(dout[0]);
      else if (got.size() == 1) begin
        n_tests++;
        if (dout[0] !== 8'h20) begin
          n_fail++;
          $display("FAIL gating_hold c%0d: got %h, want 20", c, dout[0]);
        end
      end
    end
    n_tests++;
    if (got.size() != 2 || got[0] !== 8'h20 || got[1] !== 8'h10) begin
      n_fail++;
      $display("FAIL gating_strobes: got %0d strobes (%h %h), want 2 strobes (20 10)",
               got.size(), (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 1) ? got[1] : 8'hxx);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    // Valid sample offered on the reset edge must be dropped.
    step(1'b1, 8'h7F, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step((c == 1), (c == 1) ? 8'h40 : 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (vout[i] !== exp_v[2] || dout[i] !== exp_hold[i]) begin
          n_fail++;
          $display("FAIL reset_mid inst%0d c%0d: got vld=%b data=%h, want vld=%b data=%h",
                   i, c, vout[i], dout[i], exp_v[2], exp_hold[i]);
        end
      end
      if (c < 3) begin
        n_tests++;
        if (vout[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_quiet c%0d: got vld=%b, want 0", c, vout[0]);
        end
      end else if (c == 3) begin
        n_tests++;
        if (vout[0] !== 1'b1 || dout[0] !== 8'h20) begin
          n_fail++;
          $display("FAIL reset_mid_first: got vld=%b data=%h, want vld=1 data=20", vout[0], dout[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 300; c++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (vout[i] !== exp_v[2] || dout[i] !== exp_hold[i]) begin
          n_fail++;
          $display("FAIL back_to_back inst%0d c%0d: got vld=%b data=%h, want vld=%b data=%h",
                   i, c, vout[i], dout[i], exp_v[2], exp_hold[i]);
        end
      end
      if (c >= 2) begin
        n_tests++;
        if (vout[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back_rate c%0d: got vld=%b, want 1", c, vout[3]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 61; k++) coef_tab[i][k] = 0;
    coef_tab[0][0] = 64; coef_tab[0][1] = 32; coef_tab[0][2] = 16; coef_tab[0][3] = 8;
    for (int k = 0; k < 4; k++) coef_tab[1][k] = 127;
    coef_tab[2][0] = 64;
    for (int k = 0; k < 61; k++) coef_tab[3][k] = 2;

    test_reset();
    test_impulse();
    test_pos_sat();
    test_neg_sat();
    test_valid_gating();
    test_reset_midstream();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
